// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared types and constants for the memory-side burst responder.
//   state_e   : FSM encoding (IDLE / READ / WRITE), also used on the debug port
//   OP_RD/WR  : request opcode values
//   calc_off  : number of byte-offset address bits below the word index
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Byte-offset bits of an address for a given beat width in bits.
    function automatic int calc_off(input int data_bits);
        return $clog2(data_bits / 8);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Accelerator memory request bus: burst request, write beats, read beats.
//   master : requester (MMU or bench) drives req/wr and mem_rd_ready
//   slave  : memory responder drives mem_rd_valid / mem_rd_bits
//
// Handshake: mem_req_valid is a single-cycle strobe with no ready. mem_wr_valid
// beats are always accepted. A read beat transfers on a rising edge where
// mem_rd_valid && mem_rd_ready; while mem_rd_ready is low the slave keeps
// mem_rd_valid and mem_rd_bits stable.
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int LEN_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64
) ();
    logic                 mem_req_valid;
    logic                 mem_req_opcode;
    logic [LEN_BITS-1:0]  mem_req_len;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic                 mem_wr_valid;
    logic [DATA_BITS-1:0] mem_wr_bits;
    logic                 mem_rd_valid;
    logic [DATA_BITS-1:0] mem_rd_bits;
    logic                 mem_rd_ready;

    modport master (
        output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        output mem_wr_valid, mem_wr_bits, mem_rd_ready,
        input  mem_rd_valid, mem_rd_bits
    );

    modport slave (
        input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
        output mem_rd_valid, mem_rd_bits
    );
endinterface

// File: rtl/mem_responder_ram.sv
// -----------------------------------------------------------------------------
// mem_responder_ram
// Two-port word array with registered read data on both ports.
//   i_clk, i_rst_n          : clock, async active-low reset (read regs only)
//   i_a_addr/re/we/wdata    : port A, bus side; read data updates only when re
//   o_a_rdata               : port A read data, holds between reads
//   i_b_addr/we/wdata       : port B, backdoor side; read every cycle
//   o_b_rdata               : port B read data
// Array contents are not reset. Port A wins a same-word write collision.
// -----------------------------------------------------------------------------
module mem_responder_ram #(
    parameter int DATA_BITS  = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DEPTH_LOG2-1:0] i_a_addr,
    input  logic                  i_a_re,
    input  logic                  i_a_we,
    input  logic [DATA_BITS-1:0]  i_a_wdata,
    output logic [DATA_BITS-1:0]  o_a_rdata,
    input  logic [DEPTH_LOG2-1:0] i_b_addr,
    input  logic                  i_b_we,
    input  logic [DATA_BITS-1:0]  i_b_wdata,
    output logic [DATA_BITS-1:0]  o_b_rdata
);
    logic [DATA_BITS-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_BITS-1:0] r_a_rdata;
    logic [DATA_BITS-1:0] r_b_rdata;
    logic                 w_b_blocked;

    assign w_b_blocked = i_a_we && (i_a_addr == i_b_addr);

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        if (i_b_we && !w_b_blocked) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (i_a_re) begin
                r_a_rdata <= r_mem[i_a_addr];
            end
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;
endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side target for read/write bursts, backed by mem_responder_ram.
//   clock, reset     : clock, async active-low reset
//   bus (slave)      : request / write-beat / read-beat bus
//   bd_we/addr/wdata : backdoor word write
//   bd_rdata         : backdoor read data, one-cycle latency
//   busy             : FSM not idle
//   err              : sticky protocol-error flag, cleared only by reset
//   dbg_state        : current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 32,
    parameter int MEM_DATA_BITS  = 64,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    mem_responder_if.slave            bus,
    input  logic                      bd_we,
    input  logic [MEM_DEPTH_LOG2-1:0] bd_addr,
    input  logic [MEM_DATA_BITS-1:0]  bd_wdata,
    output logic [MEM_DATA_BITS-1:0]  bd_rdata,
    output logic                      busy,
    output logic                      err,
    output logic [1:0]                dbg_state
);
    localparam int OFF = calc_off(MEM_DATA_BITS);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_WRITE = ST_WRITE;

    logic [1:0]                r_state;
    logic [MEM_DEPTH_LOG2-1:0] r_ptr;
    logic [MEM_LEN_BITS-1:0]   r_remain;
    logic                      r_rd_valid;
    logic                      r_err;

    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic [MEM_DEPTH_LOG2-1:0] w_a_addr;
    logic                      w_a_re;
    logic                      w_a_we;
    logic                      w_rd_fire;
    logic                      w_last;
    logic                      w_proto_err;
    logic [MEM_DATA_BITS-1:0]  w_a_rdata;

    // Word index: drop byte offset, keep DEPTH bits, ignore the rest.
    assign w_idx     = MEM_DEPTH_LOG2'(bus.mem_req_addr >> OFF);
    assign w_rd_fire = r_rd_valid && bus.mem_rd_ready;
    assign w_last    = (r_remain == '0);

    // Requests are only legal in IDLE; write beats only in WRITE.
    assign w_proto_err = (bus.mem_req_valid && (r_state != S_IDLE)) ||
                         (bus.mem_wr_valid  && (r_state != S_WRITE));

    // Port A address: next word to fetch on a read, current word on a write.
    always_comb begin
        w_a_addr = r_ptr;
        w_a_re   = 1'b0;
        w_a_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_req_valid && (bus.mem_req_opcode == OP_RD)) begin
                    w_a_addr = w_idx;
                    w_a_re   = 1'b1;
                end
            end
            S_READ: begin
                if (w_rd_fire && !w_last) begin
                    w_a_addr = r_ptr + 1'b1;
                    w_a_re   = 1'b1;
                end
            end
            S_WRITE: begin
                w_a_we = bus.mem_wr_valid;
            end
            default: begin
                w_a_addr = r_ptr;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_remain   <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_req_valid) begin
                        r_ptr    <= w_idx;
                        r_remain <= bus.mem_req_len;
                        if (bus.mem_req_opcode == OP_RD) begin
                            r_state    <= S_READ;
                            r_rd_valid <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_fire) begin
                        if (w_last) begin
                            r_rd_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_ptr    <= r_ptr + 1'b1;
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_wr_valid) begin
                        r_ptr    <= r_ptr + 1'b1;
                        r_remain <= r_remain - 1'b1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rd_valid <= 1'b0;
                end
            endcase
        end
    end

    mem_responder_ram #(
        .DATA_BITS  (MEM_DATA_BITS),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_a_addr  (w_a_addr),
        .i_a_re    (w_a_re),
        .i_a_we    (w_a_we),
        .i_a_wdata (bus.mem_wr_bits),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (bd_addr),
        .i_b_we    (bd_we),
        .i_b_wdata (bd_wdata),
        .o_b_rdata (bd_rdata)
    );

    assign bus.mem_rd_valid = r_rd_valid;
    assign bus.mem_rd_bits  = w_a_rdata;
    assign busy             = (r_state != S_IDLE);
    assign err              = r_err;
    assign dbg_state        = r_state;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LB = 8;
  localparam int AB = 32;
  localparam int DB = 64;
  localparam int DL = 10;

  // clock / reset
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic          bd_we;
  logic [DL-1:0] bd_addr;
  logic [DB-1:0] bd_wdata;
  logic [DB-1:0] bd_rdata;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;

  mem_responder_if #(.LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_responder #(
    .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB), .MEM_DEPTH_LOG2(DL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .bd_we     (bd_we),
    .bd_addr   (bd_addr),
    .bd_wdata  (bd_wdata),
    .bd_rdata  (bd_rdata),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [DB-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int beats_seen = 0;
  logic hold_active = 1'b0;
  logic [DB-1:0] hold_val = '0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  // monitor: pops on each read handshake, checks hold stability under stall
  always @(negedge clock) begin
    if (reset) begin
      if (hold_active && bus.mem_rd_valid) check("rd_hold", bus.mem_rd_bits, hold_val);
      if (bus.mem_rd_valid && bus.mem_rd_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got beat 0x%0h expected no beat", bus.mem_rd_bits);
        end else begin
          check("rd_beat", bus.mem_rd_bits, exp_q.pop_front());
        end
      end
      hold_active = bus.mem_rd_valid && !bus.mem_rd_ready;
      hold_val    = bus.mem_rd_bits;
    end else begin
      hold_active = 1'b0;
    end
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_write(input logic [DL-1:0] a, input logic [DB-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input string name, input logic [DL-1:0] a, input logic [DB-1:0] e);
    bd_addr = a;
    tick();
    check(name, bd_rdata, e);
  endtask

  task automatic issue(input logic op, input logic [LB-1:0] len, input logic [AB-1:0] addr);
    bus.mem_req_valid = 1'b1; bus.mem_req_opcode = op;
    bus.mem_req_len = len; bus.mem_req_addr = addr;
    tick();
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 600) begin
      tick();
      k++;
    end
    check_bit(name, busy, 1'b0);
  endtask

  initial begin
    int b0;
    int pat[5] = '{0, 0, 1, 0, 1};
    reset = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    bus.mem_req_valid = 1'b0; bus.mem_req_opcode = 1'b0; bus.mem_req_len = '0;
    bus.mem_req_addr = '0; bus.mem_wr_valid = 1'b0; bus.mem_wr_bits = '0;
    bus.mem_rd_ready = 1'b0;

    // reset state
    #22;
    check_bit("rst_rd_valid", bus.mem_rd_valid, 1'b0);
    check("rst_rd_bits", bus.mem_rd_bits, 64'h0);
    check("rst_bd_rdata", bd_rdata, 64'h0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    reset = 1'b1;
    tick();

    // 1: 4-beat read, always ready
    bd_write(10'd0, 64'h10); bd_write(10'd1, 64'h11);
    bd_write(10'd2, 64'h12); bd_write(10'd3, 64'h13);
    bus.mem_rd_ready = 1'b1;
    b0 = beats_seen;
    exp_q.push_back(64'h10); exp_q.push_back(64'h11);
    exp_q.push_back(64'h12); exp_q.push_back(64'h13);
    issue(OP_RD, 8'd3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_bit("t1_rd_valid_run", bus.mem_rd_valid, 1'b1);
      tick();
    end
    check_bit("t1_rd_valid_end", bus.mem_rd_valid, 1'b0);
    check_bit("t1_busy_end", busy, 1'b0);
    check_bit("t1_err", err, 1'b0);
    check("t1_beats", 64'(beats_seen - b0), 64'd4);

    // 2: 2-beat write at byte 0x40 (word 8)
    issue(OP_WR, 8'd1, 32'h40);
    bus.mem_wr_valid = 1'b1; bus.mem_wr_bits = 64'hAAAA;
    tick();
    bus.mem_wr_bits = 64'hBBBB;
    tick();
    bus.mem_wr_valid = 1'b0;
    check_bit("t2_busy_end", busy, 1'b0);
    check("t2_state", 64'(dbg_state), 64'(ST_IDLE));
    bd_check("t2_word8", 10'd8, 64'hAAAA);
    bd_check("t2_word9", 10'd9, 64'hBBBB);

    // 3: 2-beat read with ready pattern 0,0,1,0,1 from word 2
    bus.mem_rd_ready = 1'b0;
    b0 = beats_seen;
    exp_q.push_back(64'h12); exp_q.push_back(64'h13);
    issue(OP_RD, 8'd1, 32'h10);
    for (int i = 0; i < 5; i++) begin
      bus.mem_rd_ready = pat[i][0];
      tick();
    end
    check_bit("t3_rd_valid_end", bus.mem_rd_valid, 1'b0);
    check_bit("t3_busy_end", busy, 1'b0);
    check("t3_beats", 64'(beats_seen - b0), 64'd2);
    bus.mem_rd_ready = 1'b1;

    // 4: wrap at the top of the array
    bd_write(10'd1023, 64'hF);
    bd_write(10'd0, 64'hE);
    b0 = beats_seen;
    exp_q.push_back(64'hF); exp_q.push_back(64'hE);
    issue(OP_RD, 8'd1, 32'(1023 << 3));
    wait_idle("t4_idle");
    check("t4_beats", 64'(beats_seen - b0), 64'd2);

    // 5a: write beat while idle
    bus.mem_wr_valid = 1'b1; bus.mem_wr_bits = 64'hDEAD;
    tick();
    bus.mem_wr_valid = 1'b0;
    check_bit("t5a_err", err, 1'b1);
    check_bit("t5a_busy", busy, 1'b0);
    bd_check("t5a_word0", 10'd0, 64'hE);
    bd_check("t5a_word1023", 10'd1023, 64'hF);
    tick();
    check_bit("t5a_err_sticky", err, 1'b1);
    reset = 1'b0;
    #2;
    check_bit("t5a_err_cleared", err, 1'b0);
    reset = 1'b1;
    tick();

    // 5b: second request during a read burst
    b0 = beats_seen;
    exp_q.push_back(64'hE); exp_q.push_back(64'h11);
    exp_q.push_back(64'h12); exp_q.push_back(64'h13);
    issue(OP_RD, 8'd3, 32'h0);
    bus.mem_req_valid = 1'b1; bus.mem_req_opcode = OP_WR;
    bus.mem_req_len = 8'd0; bus.mem_req_addr = 32'h48;
    tick();
    bus.mem_req_valid = 1'b0;
    wait_idle("t5b_idle");
    check_bit("t5b_err", err, 1'b1);
    check("t5b_beats", 64'(beats_seen - b0), 64'd4);
    bd_check("t5b_word9", 10'd9, 64'hBBBB);

    // 6: async reset after 2 of 4 write beats
    bd_write(10'd0, 64'h20); bd_write(10'd1, 64'h21);
    bd_write(10'd2, 64'h22); bd_write(10'd3, 64'h23);
    issue(OP_WR, 8'd3, 32'h0);
    bus.mem_wr_valid = 1'b1; bus.mem_wr_bits = 64'hA0;
    tick();
    bus.mem_wr_bits = 64'hA1;
    tick();
    check_bit("t6_busy_mid", busy, 1'b1);
    #2;
    bus.mem_wr_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_bit("t6_rd_valid_rst", bus.mem_rd_valid, 1'b0);
    check_bit("t6_busy_rst", busy, 1'b0);
    check_bit("t6_err_rst", err, 1'b0);
    reset = 1'b1;
    tick();
    bd_check("t6_word0", 10'd0, 64'hA0);
    bd_check("t6_word1", 10'd1, 64'hA1);
    bd_check("t6_word2", 10'd2, 64'h22);
    bd_check("t6_word3", 10'd3, 64'h23);

    // 7: async reset while a read beat is stalled
    bus.mem_rd_ready = 1'b0;
    issue(OP_RD, 8'd1, 32'h10);
    check("t7_rd_bits", bus.mem_rd_bits, 64'h22);
    #2;
    reset = 1'b0;
    #1;
    check_bit("t7_rd_valid_rst", bus.mem_rd_valid, 1'b0);
    check("t7_rd_bits_rst", bus.mem_rd_bits, 64'h0);
    check_bit("t7_busy_rst", busy, 1'b0);
    reset = 1'b1;
    tick();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
